seven_seg_scanner: RTL and testbench

//  Consumes the six BCD time digits (hrs/min/sec tens+ones) and the 2-bit edit mode produced by the

---
 rtl/seg_pkg.sv | 43 ++++
 rtl/seven_seg_scanner_if.sv | 23 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/seven_seg_scanner.sv | 109 ++++++++++
 tb/tb_seven_seg_scanner.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment display constants: segment patterns, edit-mode encodings, slot indices.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {
    MODE_RUN = 2'd0,
    MODE_SEC = 2'd1,
    MODE_MIN = 2'd2,
    MODE_HRS = 2'd3
  } mode_e;

  localparam logic [2:0] IDX_SECONES = 3'd0;
  localparam logic [2:0] IDX_SECTENS = 3'd1;
  localparam logic [2:0] IDX_MINONES = 3'd2;
  localparam logic [2:0] IDX_MINTENS = 3'd3;
  localparam logic [2:0] IDX_HRSONES = 3'd4;
  localparam logic [2:0] IDX_HRSTENS = 3'd5;

  // Edit field that owns a slot; unused slots map to MODE_RUN so they never blink
  function automatic mode_e slot_field(input logic [2:0] idx);
    case (idx)
      IDX_SECONES, IDX_SECTENS: slot_field = MODE_SEC;
      IDX_MINONES, IDX_MINTENS: slot_field = MODE_MIN;
      IDX_HRSONES, IDX_HRSTENS: slot_field = MODE_HRS;
      default:                  slot_field = MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Time-digit source to display scanner bus: BCD digits and edit mode in, display drive out.
interface seven_seg_scanner_if;
  logic [1:0] mode;
  logic [3:0] hrstens;
  logic [3:0] hrsones;
  logic [3:0] mintens;
  logic [3:0] minones;
  logic [3:0] sectens;
  logic [3:0] secones;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output mode, hrstens, hrsones, mintens, minones, sectens, secones,
    input  an, seg, dp
  );

  modport slave (
    input  mode, hrstens, hrsones, mintens, minones, sectens, secones,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 8-digit multiplexed 7-segment scanner for hh.mm.ss with edit-field blink and a blank
// anti-ghost cycle between digits.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  seven_seg_scanner_if.slave   bus
);

  localparam int unsigned TICK_DIV  = CLK_HZ / (REFRESH_HZ * 8);
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned TICK_W    = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W   = $clog2(BLINK_DIV);

  logic [TICK_W-1:0]  tick_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [2:0]         idx;
  logic               load;
  logic [7:0]         an_q;
  logic [6:0]         seg_q;
  logic               dp_q;

  logic               tick_c;
  logic               blink_wrap_c;
  logic [3:0]         digit_c;
  logic [6:0]         dec_seg_c;
  logic               blank_c;
  logic [6:0]         seg_nxt_c;
  logic               dp_nxt_c;

  assign tick_c       = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign blink_wrap_c = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  // Slot mux: digit shown in the current idx slot
  always_comb begin
    digit_c = 4'd0;
    case (idx)
      IDX_SECONES: digit_c = bus.secones;
      IDX_SECTENS: digit_c = bus.sectens;
      IDX_MINONES: digit_c = bus.minones;
      IDX_MINTENS: digit_c = bus.mintens;
      IDX_HRSONES: digit_c = bus.hrsones;
      IDX_HRSTENS: digit_c = bus.hrstens;
      default:     digit_c = 4'd0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (digit_c),
    .seg (dec_seg_c)
  );

  // Blink blanking applies only to the slots of the field under edit
  always_comb begin
    blank_c   = blink_phase && (mode_e'(bus.mode) != MODE_RUN)
                && (slot_field(idx) == mode_e'(bus.mode));
    seg_nxt_c = dec_seg_c;
    if (idx > IDX_HRSTENS || blank_c) begin
      seg_nxt_c = SEG_BLANK;
    end
    dp_nxt_c  = !((idx == IDX_MINONES) || (idx == IDX_HRSONES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      idx         <= 3'd0;
      load        <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
      load     <= tick_c;
      if (tick_c) begin
        idx <= idx + 3'd1;
      end

      if (blink_wrap_c) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      // Tick blanks all anodes; the load cycle samples the digit, then lights its anode
      if (tick_c) begin
        an_q <= 8'hFF;
      end else if (load) begin
        an_q  <= ~(8'(1) << idx);
        seg_q <= seg_nxt_c;
        dp_q  <= dp_nxt_c;
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: expected slot contents are queued in each load cycle
// and compared when the anode lights and for the rest of the slot.
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic reset;
  int   k;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] sb[$];
  logic [15:0] cur;
  bit   have_exp;

  seven_seg_scanner_if bus ();

  seven_seg_scanner #(
    .CLK_HZ     (800),
    .REFRESH_HZ (10),
    .BLINK_HZ   (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t k=%0d got=%h exp=%h", tag, $time, k, got, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  // Expected {an, seg, dp} for the slot whose load cycle follows posedge k
  function automatic logic [15:0] model(input int kk);
    int         i;
    bit         phase;
    int         field;
    logic [3:0] d;
    logic [6:0] s;
    logic       p;
    logic [7:0] a;
    i     = (kk / 10) % 8;
    phase = ((kk / 40) % 2) == 1;
    field = (i < 6) ? (i / 2 + 1) : 0;
    case (i)
      0: d = bus.secones;  1: d = bus.sectens;  2: d = bus.minones;
      3: d = bus.mintens;  4: d = bus.hrsones;  5: d = bus.hrstens;
      default: d = 4'd0;
    endcase
    s = dec(d);
    if (i > 5 || (phase && bus.mode != 2'd0 && field == int'(bus.mode))) s = 7'h7F;
    p = (i == 2 || i == 4) ? 1'b0 : 1'b1;
    a = ~(8'(1) << i);
    return {a, s, p};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      have_exp = 1'b0;
    end else if (k < 10) begin
      check("an_pre_load", 16'(bus.an), 16'h00FF);
    end else if (k % 10 == 0) begin
      check("an_gap", 16'(bus.an), 16'h00FF);
      sb.push_back(model(k));
    end else if (k % 10 == 1) begin
      check("sb_depth", 16'(sb.size()), 16'd1);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        have_exp = 1'b1;
        check("slot_load", {bus.an, bus.seg, bus.dp}, cur);
      end
    end else if (have_exp) begin
      check("slot_hold", {bus.an, bus.seg, bus.dp}, cur);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_lit(input string tag, input logic [7:0] target, input int max_ph);
    bit found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (bus.an == target && (k % 10) <= max_ph) found = 1'b1;
    end
    check(tag, 16'(found), 16'd1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.mode    = 2'd0;
    bus.hrstens = 4'd1;
    bus.hrsones = 4'd2;
    bus.mintens = 4'd3;
    bus.minones = 4'd4;
    bus.sectens = 4'd5;
    bus.secones = 4'd9;
    #1;
    check("rst_an",  16'(bus.an),  16'h00FF);
    check("rst_seg", 16'(bus.seg), 16'h007F);
    check("rst_dp",  16'(bus.dp),  16'h0001);
    cycles(3);
    reset = 1'b0;
    cycles(170);

    // Asynchronous reset while idx3 is lit
    wait_lit("find_an_f7", 8'hF7, 9);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_an",  16'(bus.an),  16'h00FF);
    check("mid_rst_seg", 16'(bus.seg), 16'h007F);
    check("mid_rst_dp",  16'(bus.dp),  16'h0001);
    @(posedge clk);
    #2 reset = 1'b0;
    cycles(90);

    bus.secones = 4'hC;
    cycles(90);
    bus.secones = 4'd9;

    bus.mode = 2'd2;
    cycles(170);
    bus.mode = 2'd1;
    cycles(170);
    bus.mode = 2'd3;
    cycles(170);
    bus.mode = 2'd0;

    // Mid-slot input change must not disturb the lit digit
    bus.minones = 4'd3;
    cycles(85);
    wait_lit("find_an_fb", 8'hFB, 5);
    @(posedge clk);
    #2 bus.minones = 4'd7;
    cycles(90);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
